// File: rtl/fft8_stream_ctrl.sv
// Streaming frame controller for an N-point FFT core: loads N samples, starts the core,
// waits for completion (with timeout) and streams the bins out. Macro FFT_CTRL_BITREV_EN selects bit-reversed load addresses.
module fft8_stream_ctrl #(
  parameter int N       = 8,
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    fft_load,
  output logic [$clog2(N)-1:0]    fft_load_addr,
  output logic signed [WIDTH-1:0] fft_data_re,
  output logic signed [WIDTH-1:0] fft_data_im,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic [$clog2(N)-1:0]    fft_out_addr,
  input  logic signed [WIDTH-1:0] fft_out_re,
  input  logic signed [WIDTH-1:0] fft_out_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_LOAD, S_START, S_WAIT, S_READ_ADDR, S_READ_HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           cnt_reg, cnt_next;
  logic [AW-1:0]           k_reg, k_next;
  logic [TW-1:0]           wait_reg, wait_next;
  logic                    load_reg, load_next;
  logic [AW-1:0]           load_addr_reg, load_addr_next;
  logic signed [WIDTH-1:0] data_re_reg, data_re_next, data_im_reg, data_im_next;
  logic                    start_reg, start_next;
  logic                    err_reg, err_next;
  logic signed [WIDTH-1:0] out_re_reg, out_re_next, out_im_reg, out_im_next;
  logic [AW-1:0]           map_addr;

`ifdef FFT_CTRL_BITREV_EN
  for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
    assign map_addr[gi] = cnt_reg[AW-1-gi];
  end
`else
  assign map_addr = cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      cnt_reg       <= '0;
      k_reg         <= '0;
      wait_reg      <= '0;
      load_reg      <= 1'b0;
      load_addr_reg <= '0;
      data_re_reg   <= '0;
      data_im_reg   <= '0;
      start_reg     <= 1'b0;
      err_reg       <= 1'b0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      k_reg         <= k_next;
      wait_reg      <= wait_next;
      load_reg      <= load_next;
      load_addr_reg <= load_addr_next;
      data_re_reg   <= data_re_next;
      data_im_reg   <= data_im_next;
      start_reg     <= start_next;
      err_reg       <= err_next;
      out_re_reg    <= out_re_next;
      out_im_reg    <= out_im_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    k_next         = k_reg;
    wait_next      = wait_reg;
    load_next      = 1'b0;
    load_addr_next = load_addr_reg;
    data_re_next   = data_re_reg;
    data_im_next   = data_im_reg;
    start_next     = 1'b0;
    err_next       = 1'b0;
    out_re_next    = out_re_reg;
    out_im_next    = out_im_reg;
    unique case (state_reg)
      S_LOAD: begin
        if (in_valid) begin
          load_next      = 1'b1;
          load_addr_next = map_addr;
          data_re_next   = in_re;
          data_im_next   = in_im;
          if (cnt_reg == AW'(N - 1)) begin
            cnt_next   = '0;
            state_next = S_START;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      // The start pulse is registered, so it lands one cycle after the final load strobe.
      S_START: begin
        start_next = 1'b1;
        wait_next  = '0;
        state_next = S_WAIT;
      end
      // wait_reg==0 is the first WAIT cycle, where a done level left over from the previous frame is ignored.
      S_WAIT: begin
        if (wait_reg != '0 && fft_done) begin
          k_next     = '0;
          state_next = S_READ_ADDR;
        end else if (wait_reg == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = S_LOAD;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_READ_ADDR: begin
        out_re_next = fft_out_re;
        out_im_next = fft_out_im;
        state_next  = S_READ_HOLD;
      end
      S_READ_HOLD: begin
        if (out_ready) begin
          if (k_reg == AW'(N - 1)) begin
            k_next     = '0;
            state_next = S_LOAD;
          end else begin
            k_next     = k_reg + 1'b1;
            state_next = S_READ_ADDR;
          end
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  assign in_ready      = (state_reg == S_LOAD);
  assign busy          = (state_reg != S_LOAD);
  assign out_valid     = (state_reg == S_READ_HOLD);
  assign out_last      = out_valid && (k_reg == AW'(N - 1));
  assign fft_out_addr  = k_reg;
  assign fft_load      = load_reg;
  assign fft_load_addr = load_addr_reg;
  assign fft_data_re   = data_re_reg;
  assign fft_data_im   = data_im_reg;
  assign fft_start     = start_reg;
  assign err           = err_reg;
  assign out_re        = out_re_reg;
  assign out_im        = out_im_reg;
endmodule

// File: doc/fft8_stream_ctrl.md
FFT8_STREAM_CTRL -- requirements
Module: fft8_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, FFT points (power of 2).
REQ-002 SHALL have parameter WIDTH, default 12, signed sample width per real/imag part.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles waited for fft_done.
REQ-004 SHALL have ports; AW = log2(N). One clock; reset is synchronous and active-high.
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  input sample valid
  in_ready  out  1  input sample accepted when high with in_valid
  in_re, in_im  in  WIDTH  signed input sample
  fft_load  out  1  write strobe to fft8_top
  fft_load_addr  out  AW  write address to fft8_top
  fft_data_re, fft_data_im  out  WIDTH  write data to fft8_top
  fft_start  out  1  start pulse to fft8_top
  fft_done  in  1  completion level from fft8_top
  fft_out_addr  out  AW  read address to fft8_top
  fft_out_re, fft_out_im  in  WIDTH  read data from fft8_top
  out_valid  out  1  output bin valid
  out_ready  in  1  downstream accepts bin
  out_re, out_im  out  WIDTH  output bin Y[k]
  out_last  out  1  high with out_valid for bin N-1
  busy  out  1  high in any state other than LOAD
  err  out  1  one-cycle timeout pulse

Function
REQ-005 SHALL implement states LOAD, START, WAIT, READ_ADDR, READ_HOLD.
REQ-006 LOAD: in_ready=1; each in_valid&in_ready handshake i (0..N-1) SHALL produce, the next cycle, fft_load=1 for exactly one cycle with fft_data_re/im = accepted sample and fft_load_addr = address mapping of i (REQ-020).
REQ-007 After handshake N-1 SHALL go to START; in_ready=0 from the cycle after that handshake until LOAD is re-entered.
REQ-008 START: fft_start=1 for exactly one cycle, strictly after the final fft_load cycle; then WAIT.
REQ-009 WAIT: fft_done SHALL be ignored in the first WAIT cycle (stale level from prior frame); from the second WAIT cycle on, fft_done=1 -> READ_ADDR with k=0.
REQ-010 WAIT cycle count reaching TIMEOUT without fft_done SHALL pulse err for one cycle and return to LOAD with the sample counter cleared.
REQ-011 READ_ADDR: drive fft_out_addr=k for one cycle, then READ_HOLD; fft_out_re/im captured at the end of that cycle into out_re/out_im.
REQ-012 READ_HOLD: out_valid=1, fft_out_addr held at k, out_re/out_im stable until out_valid&out_ready.
REQ-013 On acceptance with k<N-1: k+1, READ_ADDR; with k=N-1 (out_last=1): LOAD, counters cleared.
REQ-014 Throughput with out_ready tied high: one bin per 2 cycles; N bins in 2N cycles after done is seen.
REQ-015 in_valid outside LOAD SHALL be ignored; fft_done outside WAIT ignored; out_ready with out_valid=0 ignored.
REQ-016 in_valid low in LOAD SHALL stall without losing count; counter wraps only via REQ-007 exit.
REQ-017 Data SHALL pass unmodified (no scaling, rounding or sign change); all datapath WIDTH bits.

Reset
REQ-018 rst=1 at any clock edge, including mid-frame, SHALL force LOAD, clear counters, and set next cycle: in_ready=1, fft_load=0, fft_start=0, out_valid=0, out_last=0, busy=0, err=0, fft_load_addr=0, fft_out_addr=0, fft_data_re/im=0, out_re/im=0.
REQ-019 A partially loaded frame SHALL be discarded by reset; next handshake is sample 0.

Configuration
REQ-020 Macro FFT_CTRL_BITREV_EN: defined -> fft_load_addr = bit-reverse of i over AW bits (N=8: 0,4,2,6,1,5,3,7); undefined -> fft_load_addr = i (natural order, for cores with internal reordering). Read addresses are always natural order.

Verification
REQ-021 Impulse x[0]=0x100, others 0, out_ready=1, model done 5 cycles after start -> 8 bins each 0x100+j0, out_last on bin 7 only.
REQ-022 With FFT_CTRL_BITREV_EN: inputs i=0..7 -> fft_load_addr sequence 0,4,2,6,1,5,3,7; without macro -> 0..7.
REQ-023 Toggle in_valid every other cycle -> exactly 8 fft_load pulses, one fft_start after the 8th, in_ready=0 until frame drained.
REQ-024 fft_done held high from prior frame, model raises done 10 cycles after start -> READ_ADDR entered only after the new done, not in the first WAIT cycle.
REQ-025 fft_done never asserted -> err pulse exactly TIMEOUT=64 cycles into WAIT, return to LOAD, in_ready=1.
REQ-026 out_ready low 7 cycles on bin 3, then rst mid-readout -> out_re/im stable during stall; after reset all outputs per REQ-018, next frame loads from sample 0.
